apb_timer_slave: RTL and testbench

APB responder implementing a programmable 32-bit down-counting timer with prescaler, expiry flag and interrupt output. It sits on the shared APB bus beside the GPIO and UART responders, is addressed through one bit of the master's one-hot select vector, and inserts a configurable number of wait states. It exercises the responder side of the handshake: PREADY stretching, PSLVERR generation and byte-strobe writes.

---
 rtl/apb_timer_slave.sv | 148 ++++++++++++++
 tb/tb_apb_timer_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// APB responder with a prescaled 32-bit down-counting timer, expiry flag and level interrupt.
// Optional: define TIMER_PROT_CHECK_EN to reject non-privileged writes (PPROT[0] = 0).
module apb_timer_slave #(
  parameter int unsigned SEL_INDEX   = 2,
  parameter int unsigned SLAVES_NUM  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [SLAVES_NUM-1:0] PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PADDR,
  input  logic [31:0]           PWDATA,
  input  logic [3:0]            PSTRB,
  input  logic [2:0]            PPROT,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  TIMER_IRQ
);

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  logic        en_q, en_d, auto_q, auto_d, irq_en_q, irq_en_d;
  logic        expired_q, expired_d;
  logic [31:0] load_q, load_d, count_q, count_d;
  logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic [3:0]  wait_q, wait_d;

  logic        sel, setup, access, done, wr, err, addr_ok, prot_err, tick;
  logic [7:0]  addr;
  logic [31:0] rd_val, load_wr, presc_wr;
  logic        unused_bits;

  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i+:8] = strb[i] ? wd[8*i+:8] : old[8*i+:8];
    return res;
  endfunction

  assign sel         = PSEL[SEL_INDEX];
  assign setup       = sel & ~PENABLE;
  assign access      = sel & PENABLE;
  assign PREADY      = access & (wait_q == 4'd0);
  assign done        = PREADY;
  assign addr        = PADDR[7:0];
  assign unused_bits = ^{PADDR[31:8], PPROT};

`ifdef TIMER_PROT_CHECK_EN
  assign prot_err = PWRITE & ~PPROT[0];
`else
  assign prot_err = 1'b0;
`endif

  always_comb begin
    rd_val  = 32'h0;
    addr_ok = 1'b1;
    case (addr)
      8'h00:   rd_val = {29'h0, irq_en_q, auto_q, en_q};
      8'h04:   rd_val = load_q;
      8'h08:   rd_val = count_q;
      8'h0C:   rd_val = {16'h0, presc_q};
      8'h10:   rd_val = {31'h0, expired_q};
      default: addr_ok = 1'b0;
    endcase
  end

  assign err       = ~addr_ok | (PWRITE & (addr == 8'h08)) | prot_err;
  assign wr        = done & PWRITE & ~err;
  assign PSLVERR   = done & err;
  assign PRDATA    = (done & ~err & ~PWRITE) ? rd_val : 32'h0;
  assign TIMER_IRQ = expired_q & irq_en_q;
  assign tick      = en_q & (pcnt_q == presc_q);
  assign load_wr   = strb_merge(load_q, PWDATA, PSTRB);
  assign presc_wr  = strb_merge({16'h0, presc_q}, PWDATA, PSTRB);

  always_comb begin
    en_d      = en_q;
    auto_d    = auto_q;
    irq_en_d  = irq_en_q;
    expired_d = expired_q;
    load_d    = load_q;
    count_d   = count_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    wait_d    = wait_q;

    if (setup) begin
      wait_d = WaitInit;
    end else if (access && wait_q != 4'd0) begin
      wait_d = wait_q - 4'd1;
    end

    // W1C is applied before the timer so a same-cycle expiry wins.
    if (wr && addr == 8'h10 && PSTRB[0] && PWDATA[0]) expired_d = 1'b0;
    if (wr && addr == 8'h0C) presc_d = presc_wr[15:0];

    if (en_q) pcnt_d = tick ? 16'h0 : pcnt_q + 16'h1;
    if (tick) begin
      if (count_q != 32'h0) begin
        count_d = count_q - 32'h1;
      end else begin
        expired_d = 1'b1;
        if (auto_q) count_d = load_q;
        else        en_d    = 1'b0;
      end
    end

    // Bus writes to CTRL/LOAD override the timer's own update.
    if (wr && addr == 8'h00 && PSTRB[0]) begin
      en_d     = PWDATA[0];
      auto_d   = PWDATA[1];
      irq_en_d = PWDATA[2];
      if (!en_q && PWDATA[0]) pcnt_d = 16'h0;
    end
    if (wr && addr == 8'h04) begin
      load_d  = load_wr;
      count_d = load_wr;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      expired_q <= 1'b0;
      load_q    <= 32'h0;
      count_q   <= 32'h0;
      presc_q   <= 16'h0;
      pcnt_q    <= 16'h0;
      wait_q    <= 4'h0;
    end else begin
      en_q      <= en_d;
      auto_q    <= auto_d;
      irq_en_q  <= irq_en_d;
      expired_q <= expired_d;
      load_q    <= load_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      wait_q    <= wait_d;
    end
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: directed bus checks plus randomized timer runs
// compared against a closed-form tick/expiry model.
module tb_apb_timer_slave;

  localparam int unsigned WS  = 1;
  localparam int unsigned SEL = 2;
  localparam int unsigned NS  = 8;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [NS-1:0] PSEL;
  logic          PENABLE, PWRITE;
  logic [31:0]   PADDR, PWDATA;
  logic [3:0]    PSTRB;
  logic [2:0]    PPROT;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR, TIMER_IRQ;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] rd_data;
  logic        rd_err, rd_irq;
  int          last_cyc, last_waits;

  apb_timer_slave #(.SEL_INDEX(SEL), .SLAVES_NUM(NS), .WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .TIMER_IRQ(TIMER_IRQ)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts in the cycle it is called (at #1 after an edge); returns one cycle after completion.
  task automatic xfer(input bit w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    PSEL = '0; PSEL[SEL] = 1'b1;
    PENABLE = 1'b0; PWRITE = w; PADDR = {24'h0, a}; PWDATA = d; PSTRB = s; PPROT = p;
    @(posedge PCLK); #1 PENABLE = 1'b1; #1;
    last_waits = 0;
    while (PREADY !== 1'b1 && last_waits < 40) begin
      last_waits++;
      @(posedge PCLK); #2;
    end
    if (PREADY !== 1'b1) check("apb_timeout", {31'h0, PREADY}, 32'h1);
    rd_data = PRDATA; rd_err = PSLVERR; rd_irq = TIMER_IRQ; last_cyc = cyc;
    @(posedge PCLK); #1 PSEL = '0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 4'hF, 3'b001);
  endtask

  task automatic rd(input logic [7:0] a);
    xfer(1'b0, a, 32'h0, 4'h0, 3'b001);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge PCLK); #1;
    end
  endtask

  // n = ticks elapsed since the enabling CTRL write; tick every (P+1) cycles.
  function automatic void model(input int L, input int P, input int k, input bit au,
                                output int cnt, output bit expd, output bit en);
    int n;
    n = k / (P + 1);
    if (au) begin
      cnt = L - (n % (L + 1));
      en  = 1'b1;
    end else begin
      cnt = (n >= L) ? 0 : L - n;
      en  = (n <= L);
    end
    expd = (n >= L + 1);
  endfunction

  initial begin
    int c0, L, P, k, cnt, gap, r;
    bit au, ie, expd, en;
    logic [7:0] raddr [5];
    raddr = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};

    PSEL = '0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PSTRB = '0;
    PPROT = '0; PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready", {31'h0, PREADY}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    check("rst_irq", {31'h0, TIMER_IRQ}, 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    for (int i = 0; i < 5; i++) begin
      rd(raddr[i]);
      check($sformatf("rst_read_%0h", raddr[i]), rd_data, 32'h0);
      check("rst_read_err", {31'h0, rd_err}, 32'h0);
      check("rst_read_waits", last_waits, WS);
    end

    // Another slave's select bit must not get a response.
    PSEL = 8'h01; PENABLE = 1'b1; #1;
    check("other_sel_pready", {31'h0, PREADY}, 32'h0);
    @(posedge PCLK); #1 PSEL = '0; PENABLE = 1'b0;

    rd(8'h14);
    check("unmapped_err", {31'h0, rd_err}, 32'h1);
    check("unmapped_data", rd_data, 32'h0);
    rd(8'h02);
    check("misaligned_err", {31'h0, rd_err}, 32'h1);
    wr(8'h04, 32'h12);
    wr(8'h08, 32'h55);
    check("count_wr_err", {31'h0, rd_err}, 32'h1);
    rd(8'h08);
    check("count_unchanged", rd_data, 32'h12);

    wr(8'h04, 32'h0);
    xfer(1'b1, 8'h04, 32'hAABBCCDD, 4'b0001, 3'b001);
    rd(8'h04); check("strb_load", rd_data, 32'h000000DD);
    rd(8'h08); check("strb_count", rd_data, 32'h000000DD);
    xfer(1'b1, 8'h04, 32'h11223344, 4'b0110, 3'b001);
    rd(8'h04); check("strb_load_mid", rd_data, 32'h002233DD);
    wr(8'h0C, 32'hFFFF1234);
    rd(8'h0C); check("presc_mask", rd_data, 32'h00001234);

    // One-shot: expiry exactly 4 cycles after the enabling write commits.
    wr(8'h04, 32'd3); wr(8'h0C, 32'd0); wr(8'h00, 32'h5);
    c0 = last_cyc + 1;
    wait_until(c0 + 3);
    check("oneshot_irq_early", {31'h0, TIMER_IRQ}, 32'h0);
    wait_until(c0 + 4);
    check("oneshot_irq", {31'h0, TIMER_IRQ}, 32'h1);
    rd(8'h10); check("oneshot_expired", rd_data, 32'h1);
    rd(8'h08); check("oneshot_count", rd_data, 32'h0);
    rd(8'h00); check("oneshot_ctrl", rd_data, 32'h4);
    wr(8'h10, 32'h1);
    rd(8'h10); check("w1c_clear", rd_data, 32'h0);
    check("w1c_irq", {31'h0, rd_irq}, 32'h0);

    // W1C committing on the expiry edge must leave EXPIRED set.
    wr(8'h04, 32'd9); wr(8'h0C, 32'd3); wr(8'h00, 32'h3);
    c0 = last_cyc + 1;
    wait_until(c0 + 38 - WS);
    wr(8'h10, 32'h1);
    check("collide_timing", last_cyc, c0 + 39);
    rd(8'h10); check("collide_expired", rd_data, 32'h1);
    wr(8'h00, 32'h0); wr(8'h10, 32'h1);
    rd(8'h10); check("collide_cleared", rd_data, 32'h0);

`ifdef TIMER_PROT_CHECK_EN
    xfer(1'b1, 8'h00, 32'h4, 4'hF, 3'b000);
    check("prot_err", {31'h0, rd_err}, 32'h1);
    rd(8'h00); check("prot_ctrl", rd_data, 32'h0);
`else
    xfer(1'b1, 8'h00, 32'h4, 4'hF, 3'b000);
    check("prot_ignored_err", {31'h0, rd_err}, 32'h0);
    rd(8'h00); check("prot_ignored_ctrl", rd_data, 32'h4);
`endif
    wr(8'h00, 32'h0);

    // Deselect before the completing edge aborts the write.
    wr(8'h04, 32'h77);
    PSEL = '0; PSEL[SEL] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4;
    PWDATA = 32'h99; PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1 PENABLE = 1'b1; #1;
    check("abort_wait", {31'h0, PREADY}, 32'h0);
    @(posedge PCLK); #1 PSEL = '0; PENABLE = 1'b0; #1;
    check("abort_pready", {31'h0, PREADY}, 32'h0);
    @(posedge PCLK); #1;
    rd(8'h04); check("abort_load", rd_data, 32'h77);
    rd(8'h08); check("abort_count", rd_data, 32'h77);

    // Randomized runs against the tick-count model.
    for (int it = 0; it < 6; it++) begin
      L  = int'($urandom_range(0, 6));
      P  = int'($urandom_range(0, 3));
      au = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      wr(8'h00, 32'h0); wr(8'h10, 32'h1);
      wr(8'h04, L); wr(8'h0C, P);
      wr(8'h00, {29'h0, ie, au, 1'b1});
      c0 = last_cyc + 1;
      for (int j = 0; j < 5; j++) begin
        gap = int'($urandom_range(0, 12));
        repeat (gap) begin
          @(posedge PCLK); #1;
        end
        r = int'($urandom_range(0, 2));
        rd(r == 0 ? 8'h08 : (r == 1 ? 8'h10 : 8'h00));
        k = last_cyc - c0;
        model(L, P, k, au, cnt, expd, en);
        if (r == 0)      check($sformatf("rnd%0d_count_k%0d", it, k), rd_data, cnt);
        else if (r == 1) check($sformatf("rnd%0d_status_k%0d", it, k), rd_data, {31'h0, expd});
        else             check($sformatf("rnd%0d_ctrl_k%0d", it, k), rd_data,
                               {29'h0, ie, au, en});
        check($sformatf("rnd%0d_irq_k%0d", it, k), {31'h0, rd_irq}, {31'h0, expd & ie});
      end
    end

    // Asynchronous reset while the interrupt is asserted.
    wr(8'h00, 32'h0); wr(8'h10, 32'h1);
    wr(8'h04, 32'd1); wr(8'h0C, 32'd0); wr(8'h00, 32'h7);
    c0 = last_cyc + 1;
    wait_until(c0 + 3);
    check("pre_reset_irq", {31'h0, TIMER_IRQ}, 32'h1);
    #2 PRESETn = 1'b0;
    #1 check("async_reset_irq", {31'h0, TIMER_IRQ}, 32'h0);
    @(posedge PCLK); #1 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    rd(8'h00); check("post_reset_ctrl", rd_data, 32'h0);
    rd(8'h04); check("post_reset_load", rd_data, 32'h0);
    rd(8'h08); check("post_reset_count", rd_data, 32'h0);
    rd(8'h10); check("post_reset_status", rd_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
